exu_wbck_sched: RTL and testbench
=================================

// Module: exu_wbck_sched
// PURPOSE
// - Schedules the single regfile write port among three write-back sources: ALU (single-cycle), LONGP (LSU long-pipe retire) and MDV (multi-cycle mul/div).
// - Sits between the execution units and exu_regfile.
// - Default priority is fixed: LONGP > MDV > ALU. Per-source starvation counters override it.
// - Registers the winning write into one output stage, so the regfile write lands 1 cycle after acceptance.
// PARAMETERS
// - STARVE_MAX  default 4   consecutive lost cycles after which a source is promoted to top priority (legal range 1..15)
// - PERF_W      default 16  width of the saturating conflict counter
// PORTS
// - clk                 in   1          core clock
// - rst                 in   1          asynchronous reset, active-high
// - stall_i             in   1          1 = grant nothing this cycle (debug halt)
// - alu_wbck_i_valid    in   1          ALU write-back request
// - alu_wbck_i_ready    out  1          ALU request accepted this cycle
// - alu_wbck_i_data     in   XLEN       ALU result
// - alu_wbck_i_rdidx    in   RFIDX_WIDTH  ALU destination register
// - alu_wbck_i_rdwen    in   1          0 = accept the request, no regfile write
// - longp_wbck_i_valid  in   1          LONGP write-back request
// - longp_wbck_i_ready  out  1          LONGP request accepted this cycle
// - longp_wbck_i_data   in   XLEN       LONGP result
// - longp_wbck_i_rdidx  in   RFIDX_WIDTH  LONGP destination register
// - mdv_wbck_i_valid    in   1          MDV write-back request
// - mdv_wbck_i_ready    out  1          MDV request accepted this cycle
// - mdv_wbck_i_data     in   XLEN       MDV result
// - mdv_wbck_i_rdidx    in   RFIDX_WIDTH  MDV destination register
// - rf_wbck_o_ena       out  1          registered regfile write enable
// - rf_wbck_o_data      out  XLEN       registered write data
// - rf_wbck_o_rdidx     out  RFIDX_WIDTH  registered write index
// - perf_conflict_cnt   out  PERF_W     count of cycles with 2 or more valid requests
// BEHAVIOUR
// - Reset values:
//   - rf_wbck_o_ena=0, rf_wbck_o_data=0, rf_wbck_o_rdidx=0.
//   - All starvation counters 0; perf_conflict_cnt 0.
//   - All readies are combinational; they are 0 while rst is high.
// - Handshake:
//   - A transfer occurs when valid and ready are both 1.
//   - A source holds valid, data and rdidx stable until ready.
//   - A source's valid must not depend on its ready.
//   - At most one ready is 1 per cycle; ready=0 whenever stall_i=1.
// - Grant: ready_x = valid_x & win_x & ~stall_i. The winner is chosen as follows:
//   - A source is "starved" when starve_cnt_x == STARVE_MAX.
//   - If any valid source is starved, the winner is the first starved source in the order LONGP, MDV, ALU.
//   - Otherwise the winner is the first valid source in the order LONGP, MDV, ALU.
// - Starvation counters (one per source, width 4, saturating at STARVE_MAX):
//   - Cleared when the source is granted, or when its valid=0.
//   - Incremented when valid=1, not granted and stall_i=0.
//   - Held when stall_i=1.
// - Output stage (updated every cycle, never back-pressures):
//   - On a grant: rf_wbck_o_data and rf_wbck_o_rdidx load from the winner.
//   - On a grant: rf_wbck_o_ena <= (rdidx != 0) & rdwen. rdwen is alu_wbck_i_rdwen for ALU and 1 for LONGP and MDV.
//   - Without a grant: rf_wbck_o_ena <= 0; data and idx hold their last value.
//   - Latency is exactly 1 cycle from acceptance to rf_wbck_o_ena.
//   - Back-to-back grants produce one write per cycle.
// - Conflict counter:
//   - Increments in each cycle where 2 or more valids are 1, regardless of stall_i.
//   - Saturates at all-ones; never wraps.
// - Simultaneous events:
//   - Two sources starved in the same cycle: the priority order resolves it. The loser keeps its counter at STARVE_MAX.
// - Reset mid-operation:
//   - An output write in flight is dropped (ena forced to 0 asynchronously).
//   - Counters clear; no request is accepted while rst=1.
// - x0 destination: the request is accepted and ready returned, but no write is issued.
// STRUCTURE
// - Shared package/defines.v: XLEN, RFIDX_WIDTH, WB_SRC_ALU=0, WB_SRC_LONGP=1, WB_SRC_MDV=2, WB_SRC_NUM=3.
// - One sub-module: exu_wbck_starve_cnt.
//   - Ports: clk, rst, valid, grant, stall, starved.
//   - Instantiated 3 times.
//   - The grant mux and output register stay in the top module.
// TESTING
// - Reset, then ALU-only valid with rdidx=5, data=32'h1234, rdwen=1:
//   - ready the same cycle.
//   - Next cycle ena=1, rdidx=5, data=32'h1234.
//   - The cycle after, ena=0.
// - LONGP and ALU both valid, LONGP re-requesting continuously (STARVE_MAX=4):
//   - LONGP granted for 4 cycles.
//   - ALU granted on cycle 5; LONGP resumes on cycle 6.
//   - perf_conflict_cnt = 6 after 6 cycles.
// - All three sources valid continuously:
//   - Grant order LONGP x4, MDV, ALU, then LONGP again.
//   - Never two readies in one cycle.
// - ALU rdidx=0 with rdwen=1, then ALU rdidx=7 with rdwen=0:
//   - Both are accepted.
//   - rf_wbck_o_ena stays 0 for both.
// - stall_i=1 for 10 cycles with MDV valid:
//   - mdv ready=0 throughout; the starve counter holds at 0.
//   - After stall_i drops, ready=1 on the first cycle.
// - Assert rst one cycle after a LONGP grant:
//   - rf_wbck_o_ena goes 0 immediately, with no write.
//   - After deassert, all counters are 0 and perf_conflict_cnt=0.

Source files
------------

// File: rtl/exu_wbck_sched_pkg.sv
// Shared definitions for the write-back scheduler: datapath widths, source
// indices into the per-source request vectors, the request payload struct and
// the fixed-priority pick helper.
package exu_wbck_sched_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned RFIDX_WIDTH  = 5;
    localparam int unsigned STARVE_CNT_W = 4;

    // Bit positions of each source in the valid/starved/grant vectors
    localparam int unsigned WB_SRC_ALU   = 0;
    localparam int unsigned WB_SRC_LONGP = 1;
    localparam int unsigned WB_SRC_MDV   = 2;
    localparam int unsigned WB_SRC_NUM   = 3;

    // One write-back request as seen by the output stage
    typedef struct packed {
        logic [XLEN-1:0]        data;
        logic [RFIDX_WIDTH-1:0] rdidx;
        logic                   rdwen;
    } wbck_req_t;

    // One-hot of the first set request in the order LONGP, MDV, ALU
    function automatic logic [WB_SRC_NUM-1:0] pick_first(input logic [WB_SRC_NUM-1:0] req);
        logic [WB_SRC_NUM-1:0] sel;
        sel = '0;
        if (req[WB_SRC_LONGP]) begin
            sel[WB_SRC_LONGP] = 1'b1;
        end else if (req[WB_SRC_MDV]) begin
            sel[WB_SRC_MDV] = 1'b1;
        end else if (req[WB_SRC_ALU]) begin
            sel[WB_SRC_ALU] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/exu_wbck_starve_cnt.sv
// Per-source starvation counter. Counts consecutive cycles a source was valid
// but lost arbitration; saturates at STARVE_MAX and flags "starved" there.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   valid      source is requesting this cycle
//   grant      source is accepted this cycle
//   stall      arbitration frozen; counter holds
//   starved    counter has reached STARVE_MAX
module exu_wbck_starve_cnt
    import exu_wbck_sched_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic grant,
    input  logic stall,
    output logic starved
);

    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt;

    // A granted or idle source is no longer waiting; stall freezes the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (grant || !valid) begin
            cnt <= '0;
        end else if (!stall && (cnt != CNT_MAX)) begin
            cnt <= cnt + STARVE_CNT_W'(1);
        end
    end

    assign starved = (cnt == CNT_MAX);

endmodule

// File: rtl/exu_wbck_sched.sv
// Write-back scheduler for the single regfile write port. Arbitrates among
// ALU, LONGP and MDV with fixed priority LONGP > MDV > ALU, overridden by
// per-source starvation promotion, and registers the winner into a one-stage
// output towards exu_regfile. Also counts multi-request conflict cycles.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   stall_i                  grant nothing this cycle
//   alu_wbck_i_*             ALU request (valid/ready/data/rdidx/rdwen)
//   longp_wbck_i_*           LSU long-pipe retire request (valid/ready/data/rdidx)
//   mdv_wbck_i_*             mul/div request (valid/ready/data/rdidx)
//   rf_wbck_o_*              registered regfile write (ena/data/rdidx)
//   perf_conflict_cnt        saturating count of cycles with >= 2 valids
module exu_wbck_sched
    import exu_wbck_sched_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned PERF_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,

    input  logic                   alu_wbck_i_valid,
    output logic                   alu_wbck_i_ready,
    input  logic [XLEN-1:0]        alu_wbck_i_data,
    input  logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,
    input  logic                   alu_wbck_i_rdwen,

    input  logic                   longp_wbck_i_valid,
    output logic                   longp_wbck_i_ready,
    input  logic [XLEN-1:0]        longp_wbck_i_data,
    input  logic [RFIDX_WIDTH-1:0] longp_wbck_i_rdidx,

    input  logic                   mdv_wbck_i_valid,
    output logic                   mdv_wbck_i_ready,
    input  logic [XLEN-1:0]        mdv_wbck_i_data,
    input  logic [RFIDX_WIDTH-1:0] mdv_wbck_i_rdidx,

    output logic                   rf_wbck_o_ena,
    output logic [XLEN-1:0]        rf_wbck_o_data,
    output logic [RFIDX_WIDTH-1:0] rf_wbck_o_rdidx,

    output logic [PERF_W-1:0]      perf_conflict_cnt
);

    logic [WB_SRC_NUM-1:0] valid_vec;
    logic [WB_SRC_NUM-1:0] starved_vec;
    logic [WB_SRC_NUM-1:0] cand_vec;
    logic [WB_SRC_NUM-1:0] win_vec;
    logic [WB_SRC_NUM-1:0] grant_vec;
    logic                  any_grant;
    logic                  conflict;
    wbck_req_t             sel_req;

    assign valid_vec[WB_SRC_ALU]   = alu_wbck_i_valid;
    assign valid_vec[WB_SRC_LONGP] = longp_wbck_i_valid;
    assign valid_vec[WB_SRC_MDV]   = mdv_wbck_i_valid;

    // Starved valid sources form the candidate set if there are any
    always_comb begin
        cand_vec  = valid_vec;
        win_vec   = '0;
        grant_vec = '0;
        if (|(valid_vec & starved_vec)) begin
            cand_vec = valid_vec & starved_vec;
        end
        win_vec = pick_first(cand_vec);
        if (!rst && !stall_i) begin
            grant_vec = win_vec;
        end
    end

    assign any_grant          = |grant_vec;
    assign alu_wbck_i_ready   = grant_vec[WB_SRC_ALU];
    assign longp_wbck_i_ready = grant_vec[WB_SRC_LONGP];
    assign mdv_wbck_i_ready   = grant_vec[WB_SRC_MDV];

    // Payload of the granted source; only ALU can suppress its own write
    always_comb begin
        sel_req = '0;
        if (grant_vec[WB_SRC_LONGP]) begin
            sel_req.data  = longp_wbck_i_data;
            sel_req.rdidx = longp_wbck_i_rdidx;
            sel_req.rdwen = 1'b1;
        end else if (grant_vec[WB_SRC_MDV]) begin
            sel_req.data  = mdv_wbck_i_data;
            sel_req.rdidx = mdv_wbck_i_rdidx;
            sel_req.rdwen = 1'b1;
        end else if (grant_vec[WB_SRC_ALU]) begin
            sel_req.data  = alu_wbck_i_data;
            sel_req.rdidx = alu_wbck_i_rdidx;
            sel_req.rdwen = alu_wbck_i_rdwen;
        end
    end

    exu_wbck_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve_alu (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid_vec[WB_SRC_ALU]),
        .grant   (grant_vec[WB_SRC_ALU]),
        .stall   (stall_i),
        .starved (starved_vec[WB_SRC_ALU])
    );

    exu_wbck_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve_longp (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid_vec[WB_SRC_LONGP]),
        .grant   (grant_vec[WB_SRC_LONGP]),
        .stall   (stall_i),
        .starved (starved_vec[WB_SRC_LONGP])
    );

    exu_wbck_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve_mdv (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid_vec[WB_SRC_MDV]),
        .grant   (grant_vec[WB_SRC_MDV]),
        .stall   (stall_i),
        .starved (starved_vec[WB_SRC_MDV])
    );

    // Output stage: x0 destinations and rdwen=0 are accepted without a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wbck_o_ena   <= 1'b0;
            rf_wbck_o_data  <= '0;
            rf_wbck_o_rdidx <= '0;
        end else begin
            rf_wbck_o_ena <= any_grant && (sel_req.rdidx != '0) && sel_req.rdwen;
            if (any_grant) begin
                rf_wbck_o_data  <= sel_req.data;
                rf_wbck_o_rdidx <= sel_req.rdidx;
            end
        end
    end

    assign conflict = (valid_vec[WB_SRC_ALU]   & valid_vec[WB_SRC_LONGP]) |
                      (valid_vec[WB_SRC_ALU]   & valid_vec[WB_SRC_MDV])   |
                      (valid_vec[WB_SRC_LONGP] & valid_vec[WB_SRC_MDV]);

    // Saturating conflict counter, independent of stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict_cnt <= '0;
        end else if (conflict && (perf_conflict_cnt != '1)) begin
            perf_conflict_cnt <= perf_conflict_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_exu_wbck_sched.sv
// Directed self-checking bench for exu_wbck_sched with default parameters.
module tb_exu_wbck_sched;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        alu_valid, alu_ready, alu_rdwen;
    logic [31:0] alu_data;
    logic [4:0]  alu_rdidx;
    logic        longp_valid, longp_ready;
    logic [31:0] longp_data;
    logic [4:0]  longp_rdidx;
    logic        mdv_valid, mdv_ready;
    logic [31:0] mdv_data;
    logic [4:0]  mdv_rdidx;
    logic        rf_ena;
    logic [31:0] rf_data;
    logic [4:0]  rf_rdidx;
    logic [15:0] perf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Ready vector seen by the bench: {longp, mdv, alu}
    localparam logic [2:0] G_NONE = 3'b000;
    localparam logic [2:0] G_L    = 3'b100;
    localparam logic [2:0] G_M    = 3'b010;
    localparam logic [2:0] G_A    = 3'b001;

    exu_wbck_sched #(.STARVE_MAX(4), .PERF_W(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .stall_i            (stall_i),
        .alu_wbck_i_valid   (alu_valid),
        .alu_wbck_i_ready   (alu_ready),
        .alu_wbck_i_data    (alu_data),
        .alu_wbck_i_rdidx   (alu_rdidx),
        .alu_wbck_i_rdwen   (alu_rdwen),
        .longp_wbck_i_valid (longp_valid),
        .longp_wbck_i_ready (longp_ready),
        .longp_wbck_i_data  (longp_data),
        .longp_wbck_i_rdidx (longp_rdidx),
        .mdv_wbck_i_valid   (mdv_valid),
        .mdv_wbck_i_ready   (mdv_ready),
        .mdv_wbck_i_data    (mdv_data),
        .mdv_wbck_i_rdidx   (mdv_rdidx),
        .rf_wbck_o_ena      (rf_ena),
        .rf_wbck_o_data     (rf_data),
        .rf_wbck_o_rdidx    (rf_rdidx),
        .perf_conflict_cnt  (perf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic idle_inputs();
        stall_i     = 1'b0;
        alu_valid   = 1'b0;
        alu_data    = 32'h0000_00B0;
        alu_rdidx   = 5'd2;
        alu_rdwen   = 1'b1;
        longp_valid = 1'b0;
        longp_data  = 32'h0000_00A0;
        longp_rdidx = 5'd1;
        mdv_valid   = 1'b0;
        mdv_data    = 32'h0000_00C0;
        mdv_rdidx   = 5'd3;
    endtask

    // Check this cycle's ready vector, clock it, then check the resulting write
    task automatic expect_grant(input string tag, input logic [2:0] exp_rdy);
        logic [4:0]  e_idx;
        logic [31:0] e_data;
        #1;
        check({tag, "_rdy"}, 64'({longp_ready, mdv_ready, alu_ready}), 64'(exp_rdy));
        e_idx  = (exp_rdy == G_L) ? 5'd1 : (exp_rdy == G_M) ? 5'd3 : 5'd2;
        e_data = (exp_rdy == G_L) ? 32'hA0 : (exp_rdy == G_M) ? 32'hC0 : 32'hB0;
        tick();
        check({tag, "_ena"}, 64'(rf_ena), 64'(1));
        check({tag, "_idx"}, 64'(rf_rdidx), 64'(e_idx));
        check({tag, "_data"}, 64'(rf_data), 64'(e_data));
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;

        // Reset values
        check("rst_ena", 64'(rf_ena), 64'(0));
        check("rst_data", 64'(rf_data), 64'(0));
        check("rst_idx", 64'(rf_rdidx), 64'(0));
        check("rst_perf", 64'(perf_cnt), 64'(0));
        alu_valid = 1'b1;
        #1;
        check("rst_rdy", 64'({longp_ready, mdv_ready, alu_ready}), 64'(G_NONE));
        alu_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Single ALU write: ready same cycle, write one cycle later, then idle
        alu_valid = 1'b1;
        alu_rdidx = 5'd5;
        alu_data  = 32'h1234;
        alu_rdwen = 1'b1;
        #1;
        check("alu_rdy", 64'({longp_ready, mdv_ready, alu_ready}), 64'(G_A));
        tick();
        alu_valid = 1'b0;
        check("alu_ena", 64'(rf_ena), 64'(1));
        check("alu_idx", 64'(rf_rdidx), 64'(5));
        check("alu_data", 64'(rf_data), 64'h1234);
        tick();
        check("alu_ena_off", 64'(rf_ena), 64'(0));
        check("alu_data_hold", 64'(rf_data), 64'h1234);

        // LONGP vs ALU: ALU promoted on the fifth cycle
        idle_inputs();
        apply_reset();
        longp_valid = 1'b1;
        alu_valid   = 1'b1;
        for (int i = 0; i < 4; i++) expect_grant("la_l", G_L);
        expect_grant("la_a", G_A);
        expect_grant("la_l6", G_L);
        check("la_perf", 64'(perf_cnt), 64'(6));

        // All three valid: LONGP x4, MDV, ALU, LONGP
        idle_inputs();
        apply_reset();
        longp_valid = 1'b1;
        mdv_valid   = 1'b1;
        alu_valid   = 1'b1;
        for (int i = 0; i < 4; i++) expect_grant("all_l", G_L);
        expect_grant("all_m", G_M);
        expect_grant("all_a", G_A);
        expect_grant("all_l7", G_L);
        check("all_perf", 64'(perf_cnt), 64'(7));

        // x0 destination and rdwen=0: accepted, no write
        idle_inputs();
        apply_reset();
        alu_valid = 1'b1;
        alu_rdidx = 5'd0;
        alu_data  = 32'h55;
        alu_rdwen = 1'b1;
        #1;
        check("x0_rdy", 64'({longp_ready, mdv_ready, alu_ready}), 64'(G_A));
        tick();
        check("x0_ena", 64'(rf_ena), 64'(0));
        alu_rdidx = 5'd7;
        alu_data  = 32'h77;
        alu_rdwen = 1'b0;
        #1;
        check("nowen_rdy", 64'({longp_ready, mdv_ready, alu_ready}), 64'(G_A));
        tick();
        alu_valid = 1'b0;
        check("nowen_ena", 64'(rf_ena), 64'(0));
        check("nowen_idx", 64'(rf_rdidx), 64'(7));

        // Stall with MDV valid: no grant, then immediate grant on release
        idle_inputs();
        apply_reset();
        stall_i   = 1'b1;
        mdv_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stall_rdy", 64'({longp_ready, mdv_ready, alu_ready}), 64'(G_NONE));
            tick();
            check("stall_ena", 64'(rf_ena), 64'(0));
        end
        stall_i = 1'b0;
        expect_grant("unstall_m", G_M);
        mdv_valid = 1'b0;

        // Stall with LONGP+MDV: counters held at 0, so LONGP keeps 4 grants
        stall_i     = 1'b1;
        longp_valid = 1'b1;
        mdv_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall2_rdy", 64'({longp_ready, mdv_ready, alu_ready}), 64'(G_NONE));
            tick();
        end
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) expect_grant("stall2_l", G_L);
        expect_grant("stall2_m", G_M);
        check("stall2_perf", 64'(perf_cnt), 64'(8));

        // Reset one cycle after a LONGP grant drops the write
        idle_inputs();
        apply_reset();
        longp_valid = 1'b1;
        alu_valid   = 1'b1;
        expect_grant("pre_rst_l", G_L);
        check("pre_rst_perf", 64'(perf_cnt), 64'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_ena", 64'(rf_ena), 64'(0));
        check("mid_rst_data", 64'(rf_data), 64'(0));
        check("mid_rst_rdy", 64'({longp_ready, mdv_ready, alu_ready}), 64'(G_NONE));
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_perf", 64'(perf_cnt), 64'(0));
        check("post_rst_ena", 64'(rf_ena), 64'(0));
        for (int i = 0; i < 4; i++) expect_grant("post_rst_l", G_L);
        expect_grant("post_rst_a", G_A);
        check("post_rst_perf5", 64'(perf_cnt), 64'(5));

        idle_inputs();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
